// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - load handshake bundle for the seven-segment scan controller
//
// Purpose: carries a new display value and its digit enable mask from a source
//          to seg_scan_ctrl under a valid/ready handshake.
// Signals:
//   load_valid  source -> ctrl  a new display value is offered
//   load_data   source -> ctrl  32-bit hex value, digit i = load_data[4i+3:4i]
//   load_mask   source -> ctrl  per-digit enable, bit i = 1 shows digit i
//   load_ready  ctrl -> source  controller can accept a load
// Modports: master = value source, slave = scan controller.
interface seg_scan_ctrl_if;
    logic        load_valid;
    logic [31:0] load_data;
    logic [7:0]  load_mask;
    logic        load_ready;

    modport master (
        output load_valid,
        output load_data,
        output load_mask,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        input  load_mask,
        output load_ready
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - time-multiplexed 8-digit seven-segment scan controller
//
// Purpose: steps sel through digits 0..7, holding each for REFRESH_DIV cycles,
//          and presents the matching nibble of the displayed value on num.
//          New values are staged in a one-entry pending buffer and swapped in
//          only at a frame boundary so a frame never mixes old and new digits.
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   load_if     slave modport of seg_scan_ctrl_if (load handshake)
//   num         out  nibble for the current digit
//   sel         out  current digit index
//   blank       out  current digit is masked off
//   frame_done  out  one-cycle pulse on the digit 7 -> 0 wrap
module seg_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic               clk,
    input  logic               rst,
    seg_scan_ctrl_if.slave     load_if,
    output logic [3:0]         num,
    output logic [2:0]         sel,
    output logic               blank,
    output logic               frame_done
);
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [31:0]      disp_data_q, disp_data_d;
    logic [7:0]       disp_mask_q, disp_mask_d;
    logic [31:0]      pend_data_q, pend_data_d;
    logic [7:0]       pend_mask_q, pend_mask_d;
    logic             pend_valid_q, pend_valid_d;

    logic tick;
    logic boundary;
    logic accept;

    always_comb begin
        tick     = (cnt_q == CNT_MAX);
        boundary = tick && (sel_q == 3'd7);
        // Ready comes only from pend_valid_q, so accept can never coincide
        // with the pending buffer being drained at a boundary.
        accept   = load_if.load_valid && !pend_valid_q;

        cnt_d        = tick ? '0 : cnt_q + 1'b1;
        sel_d        = tick ? sel_q + 3'd1 : sel_q;   // 3-bit wrap 7 -> 0
        disp_data_d  = disp_data_q;
        disp_mask_d  = disp_mask_q;
        pend_data_d  = pend_data_q;
        pend_mask_d  = pend_mask_q;
        pend_valid_d = pend_valid_q;

        if (boundary && pend_valid_q) begin
            disp_data_d  = pend_data_q;
            disp_mask_d  = pend_mask_q;
            pend_valid_d = 1'b0;
        end

        if (accept) begin
            pend_data_d  = load_if.load_data;
            pend_mask_d  = load_if.load_mask;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            sel_q        <= 3'd0;
            disp_data_q  <= 32'd0;
            disp_mask_q  <= 8'hFF;
            pend_data_q  <= 32'd0;
            pend_mask_q  <= 8'd0;
            pend_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sel_q        <= sel_d;
            disp_data_q  <= disp_data_d;
            disp_mask_q  <= disp_mask_d;
            pend_data_q  <= pend_data_d;
            pend_mask_q  <= pend_mask_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign load_if.load_ready = !pend_valid_q;
    assign sel        = sel_q;
    assign num        = disp_data_q[{sel_q, 2'b00} +: 4];
    assign blank      = !disp_mask_q[sel_q];
    assign frame_done = boundary;
endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the 8-digit seven-segment display. It is the driving end of the `num`/`sel` interface consumed by the hex-to-segment decoder. It holds a 32-bit hex value plus a per-digit enable mask and steps `sel` through digits 0..7 at a programmable rate, presenting the matching nibble on `num`. New values are accepted through a valid/ready handshake and applied only at a frame boundary, so a frame never shows a mix of old and new digits.

## Interface
- `REFRESH_DIV`, default 100000: clock cycles each digit is held; legal range ≥ 1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  a new display value is offered.
- `load_data`  in  32  hex value; digit i shows `load_data[4i+3:4i]`.
- `load_mask`  in  8  per-digit enable; bit i = 1 shows digit i.
- `load_ready`  out  1  controller can accept a load.
- `num`  out  4  nibble for the current digit, to the decoder.
- `sel`  out  3  current digit index, to the decoder.
- `blank`  out  1  current digit is masked off; downstream drives `an` inactive.
- `frame_done`  out  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

## Operation
- State:
  - `cnt` counts 0..REFRESH_DIV-1.
  - `sel_r` is 3 bits.
  - `disp_data` (32 bits) and `disp_mask` (8 bits) hold the value being shown.
  - `pend_data`, `pend_mask` and `pend_valid` hold the next value.
- Tick: `tick = (cnt == REFRESH_DIV-1)`. On tick, `cnt` goes to 0 and `sel_r` goes to `sel_r+1`, wrapping 7 to 0. Otherwise `cnt` increments. With REFRESH_DIV = 1, tick is asserted every cycle.
- Frame boundary: `tick && sel_r == 7`. On that cycle:
  - `frame_done` is 1.
  - If `pend_valid`: `disp_data <= pend_data`, `disp_mask <= pend_mask`, `pend_valid <= 0`.
- Handshake:
  - `load_ready = !pend_valid`, decoded from the register only, with no combinational path from `load_valid`.
  - A transfer happens when `load_valid && load_ready`: `pend_* <= load_*` and `pend_valid <= 1`.
  - While `pend_valid` = 1, further offers are held off. The source keeps `load_valid` and the data stable until accepted.
- Simultaneous boundary and offer: `load_ready` is still 0 in the boundary cycle, so there is no accept. The offer is accepted on the following cycle and displayed at the next boundary.
- Outputs:
  - `sel = sel_r`.
  - `num = disp_data[4*sel_r +: 4]`.
  - `blank = !disp_mask[sel_r]`.
  - All three are decoded from registers with no extra pipeline stage.
- Reset values:
  - `cnt = 0`, `sel_r = 0`.
  - `disp_data = 0`, `disp_mask = 8'hFF`.
  - `pend_valid = 0`, giving `load_ready = 1`.
  - Outputs: `num = 0`, `sel = 0`, `blank = 0`, `frame_done = 0`.
- Reset mid-operation discards any pending load and restarts the scan at digit 0 on the next cycle. Reset takes priority over tick and handshake.

## Timing
- Each digit is held exactly REFRESH_DIV cycles. A frame is 8·REFRESH_DIV cycles.
- After reset is released, `sel` = 0 for cycles 0..REFRESH_DIV-1, then 1, and so on.
- Load latency: an accept at cycle t is visible from the first cycle after the next frame boundary at or after t+1. That is at most 8·REFRESH_DIV cycles later, when `sel` = 0.
- `load_ready` falls the cycle after an accept. It rises the cycle after the frame boundary.
- `frame_done` is high for exactly one cycle per frame, coincident with `sel` = 7 and `cnt` = REFRESH_DIV-1.

## Test plan
All scenarios use REFRESH_DIV = 4.
- Reset: hold `rst` 2 cycles → `num=0`, `sel=0`, `blank=0`, `frame_done=0`, `load_ready=1`; then `sel` steps 0,1,…,7,0 every 4 cycles and `frame_done` pulses every 32 cycles.
- Deferred load: offer `0x12345678` with mask `FF` at `sel=2` → `load_ready` falls next cycle. Display keeps showing 0 until the boundary, then shows `num=8,7,6,5,4,3,2,1` for `sel=0..7`.
- Back-pressure: with a load pending, offer `0xDEADBEEF` → not accepted until `load_ready` rises after the boundary. It is displayed one frame later; the first value is never skipped.
- Boundary collision: assert `load_valid` with `0xCAFEF00D` exactly in the `frame_done` cycle while pending is empty → accepted that cycle and displayed after the very next boundary.
- Blanking: load `0x0000FFFF` with mask `8'h0F` → `blank=1` for `sel=4..7` and 0 for `sel=0..3`; `num=F` at `sel=0..3`.
- Mid-scan reset: assert `rst` at `sel=5` with a load pending → next cycle `sel=0`, `cnt=0`, `load_ready=1`, display 0 with all digits enabled.
